// File: rtl/eth_header_parser.sv
// GMII receive-side Ethernet header parser: captures DA/SA/EtherType (plus one
// optional 802.1Q tag), classifies the destination and emits a one-cycle verdict.
module eth_header_parser #(
  parameter int                    VLAN_EN   = 1,
  parameter int                    PROMISC   = 0,
  parameter int                    MCAST_EN  = 1,
  parameter int                    TYPE_NUM  = 3,
  parameter logic [TYPE_NUM*16-1:0] TYPE_LIST = {16'h86DD, 16'h0800, 16'h0806}
) (
  input  logic                mac_gmii_rx_clk,
  input  logic                mac_gmii_rx_rstn,
  input  logic [7:0]          mac_gmii_rxd,
  input  logic                mac_gmii_rx_dv,
  input  logic                mac_gmii_rx_er,
  input  logic                preamble_sfd_valid,
  input  logic [47:0]         local_mac,
  output logic [47:0]         hdr_dst_mac,
  output logic [47:0]         hdr_src_mac,
  output logic [15:0]         hdr_eth_type,
  output logic                hdr_vlan_present,
  output logic [15:0]         hdr_vlan_tci,
  output logic [TYPE_NUM-1:0] hdr_type_hit,
  output logic [1:0]          hdr_dst_class,
  output logic                hdr_valid,
  output logic                hdr_drop,
  output logic                hdr_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DST     = 3'd1,
    SRC     = 3'd2,
    TYPE    = 3'd3,
    TCI     = 3'd4,
    ITYPE   = 3'd5,
    PAYLOAD = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [47:0]         dst_q, dst_d;
  logic [47:0]         src_q, src_d;
  logic [15:0]         type_q, type_d;
  logic [15:0]         tci_q, tci_d;
  logic [47:0]         hdr_dst_mac_q, hdr_dst_mac_d;
  logic [47:0]         hdr_src_mac_q, hdr_src_mac_d;
  logic [15:0]         hdr_eth_type_q, hdr_eth_type_d;
  logic                hdr_vlan_present_q, hdr_vlan_present_d;
  logic [15:0]         hdr_vlan_tci_q, hdr_vlan_tci_d;
  logic [TYPE_NUM-1:0] hdr_type_hit_q, hdr_type_hit_d;
  logic [1:0]          hdr_dst_class_q, hdr_dst_class_d;
  logic                hdr_valid_q, hdr_valid_d;
  logic                hdr_drop_q, hdr_drop_d;
  logic                hdr_err_q, hdr_err_d;

  logic                data_valid_s;
  logic                in_hdr_s;
  logic                emit_s;
  logic                bcast_s;
  logic                accept_s;
  logic [15:0]         final_type_s;
  logic [TYPE_NUM-1:0] hit_s;
  logic [1:0]          class_s;

  // Destination/type classification, evaluated against the byte being captured
  always_comb begin
    data_valid_s = mac_gmii_rx_dv & ~mac_gmii_rx_er;
    in_hdr_s     = (state_q == DST) || (state_q == SRC) || (state_q == TYPE) ||
                   (state_q == TCI) || (state_q == ITYPE);
    final_type_s = {type_q[7:0], mac_gmii_rxd};
    bcast_s      = (dst_q == {48{1'b1}});
    accept_s     = (PROMISC != 0) || (dst_q == local_mac) || bcast_s ||
                   ((MCAST_EN != 0) && dst_q[40]);
    if (bcast_s) begin
      class_s = 2'd1;
    end else if (dst_q[40]) begin
      class_s = 2'd2;
    end else begin
      class_s = 2'd0;
    end
    hit_s = {TYPE_NUM{1'b0}};
    for (int i = 0; i < TYPE_NUM; i++) begin
      hit_s[i] = (final_type_s == TYPE_LIST[16*i +: 16]);
    end
  end

  // Next-state, byte capture and verdict generation
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    dst_d              = dst_q;
    src_d              = src_q;
    type_d             = type_q;
    tci_d              = tci_q;
    hdr_dst_mac_d      = hdr_dst_mac_q;
    hdr_src_mac_d      = hdr_src_mac_q;
    hdr_eth_type_d     = hdr_eth_type_q;
    hdr_vlan_present_d = hdr_vlan_present_q;
    hdr_vlan_tci_d     = hdr_vlan_tci_q;
    hdr_type_hit_d     = hdr_type_hit_q;
    hdr_dst_class_d    = hdr_dst_class_q;
    hdr_valid_d        = 1'b0;
    hdr_drop_d         = 1'b0;
    hdr_err_d          = 1'b0;
    emit_s             = 1'b0;

    // A broken header with dv still high is skipped as payload until dv falls
    if (in_hdr_s && !data_valid_s) begin
      hdr_err_d = 1'b1;
      cnt_d     = 5'd0;
      state_d   = mac_gmii_rx_dv ? PAYLOAD : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_valid_s && preamble_sfd_valid) begin
            dst_d   = {dst_q[39:0], mac_gmii_rxd};
            cnt_d   = 5'd1;
            state_d = DST;
          end else begin
            state_d = IDLE;
          end
        end
        DST: begin
          dst_d   = {dst_q[39:0], mac_gmii_rxd};
          cnt_d   = cnt_q + 5'd1;
          state_d = (cnt_q == 5'd5) ? SRC : DST;
        end
        SRC: begin
          src_d   = {src_q[39:0], mac_gmii_rxd};
          cnt_d   = cnt_q + 5'd1;
          state_d = (cnt_q == 5'd11) ? TYPE : SRC;
        end
        TYPE: begin
          type_d = final_type_s;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q != 5'd13) begin
            state_d = TYPE;
          end else if ((VLAN_EN != 0) && (final_type_s == 16'h8100)) begin
            state_d = TCI;
          end else begin
            emit_s  = 1'b1;
            state_d = PAYLOAD;
          end
        end
        TCI: begin
          tci_d   = {tci_q[7:0], mac_gmii_rxd};
          cnt_d   = cnt_q + 5'd1;
          state_d = (cnt_q == 5'd15) ? ITYPE : TCI;
        end
        ITYPE: begin
          type_d = final_type_s;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd17) begin
            emit_s  = 1'b1;
            state_d = PAYLOAD;
          end else begin
            state_d = ITYPE;
          end
        end
        PAYLOAD: begin
          cnt_d   = 5'd0;
          state_d = mac_gmii_rx_dv ? PAYLOAD : IDLE;
        end
        default: begin
          cnt_d   = 5'd0;
          state_d = IDLE;
        end
      endcase
    end

    if (emit_s) begin
      hdr_dst_mac_d      = dst_q;
      hdr_src_mac_d      = src_q;
      hdr_eth_type_d     = final_type_s;
      hdr_vlan_present_d = (state_q == ITYPE);
      hdr_vlan_tci_d     = (state_q == ITYPE) ? tci_q : 16'h0000;
      hdr_type_hit_d     = hit_s;
      hdr_dst_class_d    = class_s;
      hdr_valid_d        = accept_s && (hit_s != {TYPE_NUM{1'b0}});
      hdr_drop_d         = !(accept_s && (hit_s != {TYPE_NUM{1'b0}}));
    end else begin
      hdr_valid_d = 1'b0;
      hdr_drop_d  = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge mac_gmii_rx_clk) begin
    if (!mac_gmii_rx_rstn) begin
      state_q            <= IDLE;
      cnt_q              <= 5'd0;
      dst_q              <= 48'h0;
      src_q              <= 48'h0;
      type_q             <= 16'h0;
      tci_q              <= 16'h0;
      hdr_dst_mac_q      <= 48'h0;
      hdr_src_mac_q      <= 48'h0;
      hdr_eth_type_q     <= 16'h0;
      hdr_vlan_present_q <= 1'b0;
      hdr_vlan_tci_q     <= 16'h0;
      hdr_type_hit_q     <= {TYPE_NUM{1'b0}};
      hdr_dst_class_q    <= 2'd0;
      hdr_valid_q        <= 1'b0;
      hdr_drop_q         <= 1'b0;
      hdr_err_q          <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      dst_q              <= dst_d;
      src_q              <= src_d;
      type_q             <= type_d;
      tci_q              <= tci_d;
      hdr_dst_mac_q      <= hdr_dst_mac_d;
      hdr_src_mac_q      <= hdr_src_mac_d;
      hdr_eth_type_q     <= hdr_eth_type_d;
      hdr_vlan_present_q <= hdr_vlan_present_d;
      hdr_vlan_tci_q     <= hdr_vlan_tci_d;
      hdr_type_hit_q     <= hdr_type_hit_d;
      hdr_dst_class_q    <= hdr_dst_class_d;
      hdr_valid_q        <= hdr_valid_d;
      hdr_drop_q         <= hdr_drop_d;
      hdr_err_q          <= hdr_err_d;
    end
  end

  assign hdr_dst_mac      = hdr_dst_mac_q;
  assign hdr_src_mac      = hdr_src_mac_q;
  assign hdr_eth_type     = hdr_eth_type_q;
  assign hdr_vlan_present = hdr_vlan_present_q;
  assign hdr_vlan_tci     = hdr_vlan_tci_q;
  assign hdr_type_hit     = hdr_type_hit_q;
  assign hdr_dst_class    = hdr_dst_class_q;
  assign hdr_valid        = hdr_valid_q;
  assign hdr_drop         = hdr_drop_q;
  assign hdr_err          = hdr_err_q;

endmodule

// File: tb/tb_eth_header_parser.sv
// Directed bench for eth_header_parser: three instances (default, PROMISC=1,
// VLAN_EN=0) share one GMII stimulus stream.
module tb_eth_header_parser;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        dv = 1'b0;
  logic        er = 1'b0;
  logic        sfd = 1'b0;
  logic [47:0] local_mac = 48'h020000000001;

  logic [47:0] o_dst   [3];
  logic [47:0] o_src   [3];
  logic [15:0] o_type  [3];
  logic        o_vlan  [3];
  logic [15:0] o_tci   [3];
  logic [2:0]  o_hit   [3];
  logic [1:0]  o_class [3];
  logic        o_valid [3];
  logic        o_drop  [3];
  logic        o_err   [3];

  logic [7:0]  frm [18];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  eth_header_parser u_dut0 (
    .mac_gmii_rx_clk(clk), .mac_gmii_rx_rstn(rstn), .mac_gmii_rxd(rxd),
    .mac_gmii_rx_dv(dv), .mac_gmii_rx_er(er), .preamble_sfd_valid(sfd),
    .local_mac(local_mac), .hdr_dst_mac(o_dst[0]), .hdr_src_mac(o_src[0]),
    .hdr_eth_type(o_type[0]), .hdr_vlan_present(o_vlan[0]), .hdr_vlan_tci(o_tci[0]),
    .hdr_type_hit(o_hit[0]), .hdr_dst_class(o_class[0]), .hdr_valid(o_valid[0]),
    .hdr_drop(o_drop[0]), .hdr_err(o_err[0]));

  eth_header_parser #(.PROMISC(1)) u_dut1 (
    .mac_gmii_rx_clk(clk), .mac_gmii_rx_rstn(rstn), .mac_gmii_rxd(rxd),
    .mac_gmii_rx_dv(dv), .mac_gmii_rx_er(er), .preamble_sfd_valid(sfd),
    .local_mac(local_mac), .hdr_dst_mac(o_dst[1]), .hdr_src_mac(o_src[1]),
    .hdr_eth_type(o_type[1]), .hdr_vlan_present(o_vlan[1]), .hdr_vlan_tci(o_tci[1]),
    .hdr_type_hit(o_hit[1]), .hdr_dst_class(o_class[1]), .hdr_valid(o_valid[1]),
    .hdr_drop(o_drop[1]), .hdr_err(o_err[1]));

  eth_header_parser #(.VLAN_EN(0)) u_dut2 (
    .mac_gmii_rx_clk(clk), .mac_gmii_rx_rstn(rstn), .mac_gmii_rxd(rxd),
    .mac_gmii_rx_dv(dv), .mac_gmii_rx_er(er), .preamble_sfd_valid(sfd),
    .local_mac(local_mac), .hdr_dst_mac(o_dst[2]), .hdr_src_mac(o_src[2]),
    .hdr_eth_type(o_type[2]), .hdr_vlan_present(o_vlan[2]), .hdr_vlan_tci(o_tci[2]),
    .hdr_type_hit(o_hit[2]), .hdr_dst_class(o_class[2]), .hdr_valid(o_valid[2]),
    .hdr_drop(o_drop[2]), .hdr_err(o_err[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulses(input string tag, input int k, input logic v, input logic d, input logic e);
    chk({tag, "_valid"}, {63'd0, o_valid[k]}, {63'd0, v});
    chk({tag, "_drop"},  {63'd0, o_drop[k]},  {63'd0, d});
    chk({tag, "_err"},   {63'd0, o_err[k]},   {63'd0, e});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic e, input logic s);
    rxd = d; dv = v; er = e; sfd = s;
  endtask

  task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                       input logic [15:0] tci, input logic [15:0] inner);
    for (int i = 0; i < 6; i++) begin
      frm[i]     = dst[47-8*i -: 8];
      frm[6 + i] = src[47-8*i -: 8];
    end
    frm[12] = et[15:8];    frm[13] = et[7:0];
    frm[14] = tci[15:8];   frm[15] = tci[7:0];
    frm[16] = inner[15:8]; frm[17] = inner[7:0];
  endtask

  // Drives bytes a..b, one per cycle, and returns on the negedge after byte b
  task automatic send_range(input int a, input int b);
    for (int i = a; i <= b; i++) begin
      drive(frm[i], 1'b1, 1'b0, (i == 0));
      tick();
    end
  endtask

  task automatic go_idle(input int n);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    pulses("rst", 0, 1'b0, 1'b0, 1'b0);
    chk("rst_dst",  {16'd0, o_dst[0]}, 64'd0);
    chk("rst_type", {48'd0, o_type[0]}, 64'd0);
    chk("rst_hit",  {61'd0, o_hit[0]}, 64'd0);
    rstn = 1'b1;
    tick();

    // Broadcast ARP, untagged
    build(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0806, 16'h0000, 16'h0000);
    send_range(0, 12);
    pulses("bc_early", 0, 1'b0, 1'b0, 1'b0);
    send_range(13, 13);
    pulses("bc", 0, 1'b1, 1'b0, 1'b0);
    chk("bc_hit",   {61'd0, o_hit[0]}, 64'd1);
    chk("bc_class", {62'd0, o_class[0]}, 64'd1);
    chk("bc_vlan",  {63'd0, o_vlan[0]}, 64'd0);
    chk("bc_type",  {48'd0, o_type[0]}, 64'h0806);
    chk("bc_dst",   {16'd0, o_dst[0]}, 64'hFFFFFFFFFFFF);
    chk("bc_src",   {16'd0, o_src[0]}, 64'h001122334455);
    drive(8'hAA, 1'b1, 1'b0, 1'b0);
    tick();
    pulses("bc_after", 0, 1'b0, 1'b0, 1'b0);
    go_idle(2);

    // Tagged frame to local MAC; VLAN_EN=0 instance drops it as plain 0x8100
    build(48'h020000000001, 48'h0A0B0C0D0E0F, 16'h8100, 16'h2064, 16'h0800);
    send_range(0, 13);
    pulses("tag_novlan", 2, 1'b0, 1'b1, 1'b0);
    chk("tag_novlan_type", {48'd0, o_type[2]}, 64'h8100);
    chk("tag_novlan_vlan", {63'd0, o_vlan[2]}, 64'd0);
    pulses("tag_mid", 0, 1'b0, 1'b0, 1'b0);
    send_range(14, 16);
    pulses("tag_b16", 0, 1'b0, 1'b0, 1'b0);
    send_range(17, 17);
    pulses("tag", 0, 1'b1, 1'b0, 1'b0);
    chk("tag_tci",   {48'd0, o_tci[0]}, 64'h2064);
    chk("tag_type",  {48'd0, o_type[0]}, 64'h0800);
    chk("tag_hit",   {61'd0, o_hit[0]}, 64'd2);
    chk("tag_vlan",  {63'd0, o_vlan[0]}, 64'd1);
    chk("tag_class", {62'd0, o_class[0]}, 64'd0);
    go_idle(2);

    // Unicast to a foreign station: dropped unless promiscuous
    build(48'h020000000099, 48'h0A0B0C0D0E0F, 16'h0800, 16'h0000, 16'h0000);
    send_range(0, 13);
    pulses("uc", 0, 1'b0, 1'b1, 1'b0);
    pulses("uc_promisc", 1, 1'b1, 1'b0, 1'b0);
    chk("uc_hit", {61'd0, o_hit[0]}, 64'd2);
    go_idle(2);

    // Multicast destination, accepted by default
    build(48'h01005E000001, 48'h0A0B0C0D0E0F, 16'h86DD, 16'h0000, 16'h0000);
    send_range(0, 13);
    pulses("mc", 0, 1'b1, 1'b0, 1'b0);
    chk("mc_class", {62'd0, o_class[0]}, 64'd2);
    chk("mc_hit",   {61'd0, o_hit[0]}, 64'd4);
    go_idle(2);

    // Accepted address, unknown EtherType
    build(48'h020000000001, 48'h0A0B0C0D0E0F, 16'h88CC, 16'h0000, 16'h0000);
    send_range(0, 13);
    pulses("lldp", 0, 1'b0, 1'b1, 1'b0);
    chk("lldp_hit", {61'd0, o_hit[0]}, 64'd0);
    go_idle(2);

    // dv drops after byte 9: error pulse, fields hold the LLDP frame
    build(48'hFFFFFFFFFFFF, 48'h112233445566, 16'h0800, 16'h0000, 16'h0000);
    send_range(0, 9);
    go_idle(1);
    pulses("dvdrop", 0, 1'b0, 1'b0, 1'b1);
    chk("dvdrop_dst",  {16'd0, o_dst[0]}, 64'h020000000001);
    chk("dvdrop_type", {48'd0, o_type[0]}, 64'h88CC);
    tick();
    pulses("dvdrop_after", 0, 1'b0, 1'b0, 1'b0);

    // rx_er mid-header: error pulse, rest of frame ignored even with sfd high
    send_range(0, 4);
    drive(8'h55, 1'b1, 1'b1, 1'b0);
    tick();
    pulses("rxer", 0, 1'b0, 1'b0, 1'b1);
    drive(8'hFF, 1'b1, 1'b0, 1'b1);
    repeat (16) tick();
    pulses("rxer_ign", 0, 1'b0, 1'b0, 1'b0);
    chk("rxer_type", {48'd0, o_type[0]}, 64'h88CC);
    go_idle(2);

    // Next frame after errors parses normally
    send_range(0, 13);
    pulses("recover", 0, 1'b1, 1'b0, 1'b0);
    chk("recover_src", {16'd0, o_src[0]}, 64'h112233445566);
    go_idle(2);

    // Reset at byte 7 abandons the frame silently
    send_range(0, 6);
    drive(frm[7], 1'b1, 1'b0, 1'b0);
    rstn = 1'b0;
    tick();
    pulses("midrst", 0, 1'b0, 1'b0, 1'b0);
    chk("midrst_dst", {16'd0, o_dst[0]}, 64'd0);
    rstn = 1'b1;
    send_range(8, 13);
    drive(8'h00, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    pulses("midrst_tail", 0, 1'b0, 1'b0, 1'b0);
    chk("midrst_tail_type", {48'd0, o_type[0]}, 64'd0);
    go_idle(2);
    send_range(0, 13);
    pulses("postrst", 0, 1'b1, 1'b0, 1'b0);
    chk("postrst_dst", {16'd0, o_dst[0]}, 64'hFFFFFFFFFFFF);
    go_idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
